// File: rtl/ram_stream_fifo_pkg.sv
// Shared defaults and types for the block-RAM backed streaming FIFO.
package ram_stream_fifo_pkg;
   localparam int DATA_W         = 32;
   localparam int BLOCLSIZE_DEF  = 10;
   localparam int BASICSIZE_DEF  = 2**(BLOCLSIZE_DEF+1);
   localparam int READ_LAT_DEF   = 1;
   localparam int OBUF_DEPTH_DEF = 2;

   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/ram_stream_fifo_if.sv
// Stream-in, stream-out and RAM-array port bundle of the FIFO front-end.
interface ram_stream_fifo_if
   import ram_stream_fifo_pkg::*;
#(
   parameter int BLOCLSIZE = BLOCLSIZE_DEF
);
   logic               in_valid;
   logic               in_ready;
   word_t              in_data;
   logic               out_valid;
   logic               out_ready;
   word_t              out_data;
   logic [BLOCLSIZE:0] mem_w_addr;
   word_t              mem_w_din;
   logic               mem_w_enb;
   logic [BLOCLSIZE:0] mem_r_addr;
   word_t              mem_r_dout;

   // slave: the FIFO itself; master: producer/consumer/array side
   modport slave (
      input  in_valid, in_data, out_ready, mem_r_dout,
      output in_ready, out_valid, out_data, mem_w_addr, mem_w_din, mem_w_enb, mem_r_addr
   );
   modport master (
      output in_valid, in_data, out_ready, mem_r_dout,
      input  in_ready, out_valid, out_data, mem_w_addr, mem_w_din, mem_w_enb, mem_r_addr
   );
endinterface

// File: rtl/ram_fifo_obuf.sv
// Small register FIFO catching RAM read returns; head is presented combinationally.
module ram_fifo_obuf
   import ram_stream_fifo_pkg::*;
#(
   parameter int DEPTH = OBUF_DEPTH_DEF,
   parameter int W     = DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic [W-1:0]               i_din,
   input  logic                       i_pop,
   output logic [W-1:0]               o_dout,
   output logic [$clog2(DEPTH+1)-1:0] o_cnt,
   output logic                       o_empty
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][W-1:0] r_mem;
   logic [IW-1:0]           r_head, r_tail;
   logic [CW-1:0]           r_cnt;
   logic                    w_do_push, w_do_pop;

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
      return (p == IW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign w_do_pop  = i_pop & (r_cnt != '0);
   assign w_do_push = i_push & ((r_cnt != CW'(DEPTH)) | w_do_pop);
   assign o_dout    = r_mem[r_head];
   assign o_cnt     = r_cnt;
   assign o_empty   = (r_cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem  <= '0;
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else if (i_clr) begin
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_tail] <= i_din;
            r_tail        <= nxt(r_tail);
         end
         if (w_do_pop) r_head <= nxt(r_head);
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

// File: rtl/ram_stream_fifo.sv
// Streaming FIFO front-end over a 1R1W block-RAM array with registered read latency.
module ram_stream_fifo
   import ram_stream_fifo_pkg::*;
#(
   parameter int BLOCLSIZE  = BLOCLSIZE_DEF,
   parameter int READ_LAT   = READ_LAT_DEF,
   parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   ram_stream_fifo_if.slave     bus,
   output logic [BLOCLSIZE+2:0] count
);
   localparam int AW    = BLOCLSIZE + 1;
   localparam int PW    = BLOCLSIZE + 2;
   localparam int CW    = BLOCLSIZE + 3;
   localparam int DEPTH = 2**AW;
   localparam int IFW   = $clog2(READ_LAT+1);
   localparam int OBW   = $clog2(OBUF_DEPTH+1);

   logic [PW-1:0]     r_wr_ptr, r_rd_ptr, w_ram_used;
   logic [AW-1:0]     r_last_raddr;
   logic [READ_LAT:1] r_vld_pipe;
   logic [IFW-1:0]    w_inflight;
   logic [OBW-1:0]    w_obuf_cnt;
   logic              w_push, w_pop, w_issue, w_space, w_obuf_empty;
   word_t             w_obuf_dout;

   // ram_used only sees registered wr_ptr, so a word is never read in its write cycle
   assign w_ram_used   = r_wr_ptr - r_rd_ptr;
   assign bus.in_ready = rst & ~flush & (w_ram_used < PW'(DEPTH));
   assign w_push       = bus.in_valid & bus.in_ready;
   assign w_pop        = bus.out_valid & bus.out_ready & ~flush;

   always_comb begin
      w_inflight = '0;
      for (int i = 1; i <= READ_LAT; i++) w_inflight = w_inflight + IFW'(r_vld_pipe[i]);
   end

   // a read is only launched when its return already has a reserved obuf slot
   assign w_space = (CW'(w_inflight) + CW'(w_obuf_cnt)) < (CW'(OBUF_DEPTH) + CW'(w_pop));
   assign w_issue = ~flush & (w_ram_used != '0) & w_space;

   assign bus.mem_w_enb  = w_push;
   assign bus.mem_w_addr = r_wr_ptr[AW-1:0];
   assign bus.mem_w_din  = bus.in_data;
   assign bus.mem_r_addr = w_issue ? r_rd_ptr[AW-1:0] : r_last_raddr;
   assign bus.out_valid  = ~w_obuf_empty;
   assign bus.out_data   = w_obuf_dout;

   assign count = CW'(w_ram_used) + CW'(w_inflight) + CW'(w_obuf_cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_last_raddr <= '0;
         r_vld_pipe   <= '0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_vld_pipe <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_issue) begin
            r_rd_ptr     <= r_rd_ptr + 1'b1;
            r_last_raddr <= r_rd_ptr[AW-1:0];
         end
         r_vld_pipe[1] <= w_issue;
         for (int i = 2; i <= READ_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
   end

   // clearing the obuf on flush also drops any stale return landing that cycle
   ram_fifo_obuf #(
      .DEPTH (OBUF_DEPTH),
      .W     (DATA_W)
   ) u_obuf (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (flush),
      .i_push  (r_vld_pipe[READ_LAT]),
      .i_din   (bus.mem_r_dout),
      .i_pop   (w_pop),
      .o_dout  (w_obuf_dout),
      .o_cnt   (w_obuf_cnt),
      .o_empty (w_obuf_empty)
   );
endmodule

// File: tb/tb_ram_stream_fifo.sv
// Bench for ram_stream_fifo: array model, queue reference, table and directed sequences.
module tb_ram_stream_fifo;
   import ram_stream_fifo_pkg::*;

   localparam int BLS   = 3;
   localparam int RL    = 1;
   localparam int OBD   = 2;
   localparam int DEPTH = 2**(BLS+1);

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           flush = 1'b0;
   logic [BLS+2:0] count;

   ram_stream_fifo_if #(.BLOCLSIZE(BLS)) bus ();

   ram_stream_fifo #(
      .BLOCLSIZE  (BLS),
      .READ_LAT   (RL),
      .OBUF_DEPTH (OBD)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   // behavioural 1R1W array with RL-cycle registered read
   logic [31:0] ram [DEPTH];
   logic [31:0] rd_pipe [RL];
   always @(posedge clk) begin
      if (bus.mem_w_enb) ram[bus.mem_w_addr] <= bus.mem_w_din;
      rd_pipe[0] <= ram[bus.mem_r_addr];
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_r_dout = rd_pipe[RL-1];

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: the FIFO is just an ordered queue of accepted words
   always @(negedge clk) begin
      if (!rst || flush) begin
         q.delete();
      end else begin
         check("mon_count", 32'(count), 32'(q.size()));
         if (q.size() < DEPTH) check("mon_in_ready_room", 32'(bus.in_ready), 32'd1);
         if (q.size() == 0) check("mon_out_valid_empty", 32'(bus.out_valid), 32'd0);
         if (bus.out_valid && bus.out_ready && q.size() != 0)
            check("mon_out_data", bus.out_data, q.pop_front());
         if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
      end
   end

   task automatic drive(input logic v, input logic [31:0] d, input logic r);
      @(posedge clk); #1;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
   endtask

   typedef struct {
      logic [31:0] din;
      logic [31:0] exp_data;
      int          exp_cycle;
   } vec_t;
   vec_t tbl [5];

   int acc, got, sent, k, seen;

   initial begin
      tbl[0] = '{32'hA0, 32'hA0, 3};
      tbl[1] = '{32'hA1, 32'hA1, 4};
      tbl[2] = '{32'hA2, 32'hA2, 5};
      tbl[3] = '{32'hA3, 32'hA3, 6};
      tbl[4] = '{32'hA4, 32'hA4, 7};

      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_mem_r_addr", 32'(bus.mem_r_addr), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // idle after reset release
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("idle_out_valid", 32'(bus.out_valid), 0);
         check("idle_in_ready", 32'(bus.in_ready), 1);
         check("idle_count", 32'(count), 0);
         check("idle_mem_w_enb", 32'(bus.mem_w_enb), 0);
      end

      // back-to-back A0..A4: first word out in cycle 3
      k = 0;
      for (int c = 0; c < 12; c++) begin
         if (c < 5) drive(1'b1, tbl[c].din, 1'b1);
         else       drive(1'b0, 32'h0, 1'b1);
         @(negedge clk);
         if (c < 5) check("seq_mem_w_addr", 32'(bus.mem_w_addr), 32'(c));
         if (bus.out_valid) begin
            if (k < 5) begin
               check("seq_data", bus.out_data, tbl[k].exp_data);
               check("seq_cycle", 32'(c), 32'(tbl[k].exp_cycle));
            end
            k++;
         end
      end
      check("seq_total", 32'(k), 5);

      // fill with consumer stalled: RAM 16 + obuf 2
      acc = 0;
      for (int i = 0; i < 30; i++) begin
         drive(1'b1, 32'h100 + 32'(i), 1'b0);
         @(negedge clk);
         if (bus.in_ready) acc++;
      end
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check("fill_accepted", 32'(acc), 18);
      check("fill_count", 32'(count), 18);
      check("fill_in_ready", 32'(bus.in_ready), 0);
      check("fill_out_valid", 32'(bus.out_valid), 1);
      check("fill_head", bus.out_data, 32'h100);
      got = 0;
      for (int t = 0; t < 40; t++) begin
         drive(1'b0, 32'h0, 1'b1);
         @(negedge clk);
         if (bus.out_valid) got++;
      end
      check("drain_got", 32'(got), 18);
      check("drain_count", 32'(count), 0);

      // random stream with out_ready 1,0,0,1 and pointer wrap
      sent = 0; got = 0;
      for (int t = 0; t < 3000 && got < 100; t++) begin
         @(posedge clk); #1;
         bus.out_ready = ((t % 4) == 0) || ((t % 4) == 3);
         if (sent < 100) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = $urandom;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) sent++;
         if (bus.out_valid && bus.out_ready) got++;
      end
      check("stream_sent", 32'(sent), 100);
      check("stream_got", 32'(got), 100);
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check("stream_count", 32'(count), 0);

      // flush with a read in flight
      for (int i = 0; i < 5; i++) drive(1'b1, 32'hF0 + 32'(i), 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b1);
      @(posedge clk); #1;
      flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD; bus.out_ready = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 32'(bus.in_ready), 0);
      check("flush_mem_w_enb", 32'(bus.mem_w_enb), 0);
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      @(negedge clk);
      check("post_flush_count", 32'(count), 0);
      check("post_flush_out_valid", 32'(bus.out_valid), 0);
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         check("post_flush_no_stale", 32'(bus.out_valid), 0);
      end
      drive(1'b1, 32'h55, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      seen = 0;
      for (int t = 0; t < 10 && seen == 0; t++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1;
            check("post_flush_first", bus.out_data, 32'h55);
         end
         if (seen == 0) drive(1'b0, 32'h0, 1'b0);
      end
      check("post_flush_seen", 32'(seen), 1);
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check("post_flush_empty", 32'(count), 0);

      // async reset mid-stream
      for (int i = 0; i < 7; i++) drive(1'b1, 32'h700 + 32'(i), 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check("pre_rst_count", 32'(count), 7);
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = 32'hBAD; bus.out_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("arst_out_valid", 32'(bus.out_valid), 0);
      check("arst_count", 32'(count), 0);
      check("arst_mem_w_enb", 32'(bus.mem_w_enb), 0);
      check("arst_mem_w_addr", 32'(bus.mem_w_addr), 0);
      check("arst_mem_r_addr", 32'(bus.mem_r_addr), 0);
      check("arst_out_data", bus.out_data, 0);
      drive(1'b0, 32'h0, 1'b1);
      @(posedge clk); #1 rst = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         check("after_rst_out_valid", 32'(bus.out_valid), 0);
         check("after_rst_count", 32'(count), 0);
         check("after_rst_in_ready", 32'(bus.in_ready), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
